// File: rtl/hog_cell_hist_stream_pkg.sv
// Shared defaults, FSM state type and bin-wrap helper for the HOG cell histogram stream.
package hog_hist_pkg;

  localparam int NBINS_DEF   = 9;
  localparam int MAG_W_DEF   = 16;
  localparam int FRAC_W_DEF  = 8;
  localparam int CELL_PX_DEF = 64;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN  = 2'd1,
    OUTPUT = 2'd2
  } histState_t;

  // Neighbouring orientation bin; the last bin wraps to bin 0.
  function automatic int next_bin(input int b, input int nbins);
    return (b == nbins - 1) ? 0 : b + 1;
  endfunction

endpackage

// File: rtl/hog_cell_hist_stream_if.sv
// Sample-in / histogram-out handshake bundle for hog_cell_hist_stream.
interface hog_cell_hist_stream_if #(
  parameter int NBINS   = 9,
  parameter int MAG_W   = 16,
  parameter int FRAC_W  = 8,
  parameter int CELL_PX = 64,
  parameter int ACC_W   = MAG_W + $clog2(CELL_PX)
);
  localparam int BIN_W = $clog2(NBINS);

  logic                      iValid;
  logic                      oReady;
  logic [MAG_W-1:0]          iMag;
  logic [BIN_W+FRAC_W-1:0]   iAgl;
  logic                      oValid;
  logic                      iReady;
  logic [NBINS*ACC_W-1:0]    oBins;
  logic                      oErr;

  modport slave (
    input  iValid, iMag, iAgl, iReady,
    output oReady, oValid, oBins, oErr
  );

  modport master (
    output iValid, iMag, iAgl, iReady,
    input  oReady, oValid, oBins, oErr
  );
endinterface

// File: rtl/hog_bin_split.sv
// P1 stage: splits one magnitude between bin b and its wrapped neighbour, with range check.
module hog_bin_split
  import hog_hist_pkg::*;
#(
  parameter int NBINS  = NBINS_DEF,
  parameter int MAG_W  = MAG_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int BIN_W  = $clog2(NBINS)
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  input  logic                    iEn,
  input  logic [MAG_W-1:0]        iMag,
  input  logic [BIN_W+FRAC_W-1:0] iAgl,
  output logic                    oValid,
  output logic                    oErr,
  output logic [BIN_W-1:0]        oBin,
  output logic [BIN_W-1:0]        oBin1,
  output logic [MAG_W-1:0]        oLo,
  output logic [MAG_W-1:0]        oHi
);
  // One extra bit so a power-of-two NBINS does not alias to zero.
  localparam logic [BIN_W:0] NBINS_V = (BIN_W + 1)'(NBINS);

  logic [BIN_W-1:0]        b;
  logic [FRAC_W-1:0]       f;
  logic [MAG_W+FRAC_W-1:0] prod;
  logic [MAG_W-1:0]        hi;
  logic [BIN_W-1:0]        b1;
  logic                    inRange;

  assign b       = iAgl[BIN_W+FRAC_W-1:FRAC_W];
  assign f       = iAgl[FRAC_W-1:0];
  assign prod    = (MAG_W + FRAC_W)'(iMag) * (MAG_W + FRAC_W)'(f);
  assign hi      = MAG_W'(prod >> FRAC_W);
  assign b1      = BIN_W'(next_bin(int'(b), NBINS));
  assign inRange = ({1'b0, b} < NBINS_V);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oValid <= 1'b0;
      oErr   <= 1'b0;
      oBin   <= '0;
      oBin1  <= '0;
      oLo    <= '0;
      oHi    <= '0;
    end else begin
      oValid <= iEn;
      if (iEn) begin
        // Out-of-range samples still flow through so the cell count stays exact.
        oErr  <= !inRange;
        oBin  <= inRange ? b : '0;
        oBin1 <= inRange ? b1 : '0;
        oLo   <= inRange ? (iMag - hi) : '0;
        oHi   <= inRange ? hi : '0;
      end
    end
  end

endmodule

// File: rtl/hog_cell_hist_stream.sv
// Streaming HOG cell histogram: FSM, sample counter and per-bin accumulators.
// Optional saturating accumulation when HOG_HIST_ACC_SAT_EN is defined; wraps otherwise.
module hog_cell_hist_stream
  import hog_hist_pkg::*;
#(
  parameter int NBINS   = NBINS_DEF,
  parameter int MAG_W   = MAG_W_DEF,
  parameter int FRAC_W  = FRAC_W_DEF,
  parameter int CELL_PX = CELL_PX_DEF,
  parameter int BIN_W   = $clog2(NBINS),
  parameter int ACC_W   = MAG_W + $clog2(CELL_PX)
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  hog_cell_hist_stream_if.slave  bus
);
  localparam int CNT_W = $clog2(CELL_PX);
  localparam int SUM_W = ((ACC_W > MAG_W) ? ACC_W : MAG_W) + 2;

  histState_t        stateReg;
  logic [CNT_W-1:0]  cntReg;
  logic              errReg;
  logic              accept;
  logic              outDone;

  logic              p1Valid;
  logic              p1Err;
  logic [BIN_W-1:0]  p1Bin;
  logic [BIN_W-1:0]  p1Bin1;
  logic [MAG_W-1:0]  p1Lo;
  logic [MAG_W-1:0]  p1Hi;

  assign accept     = bus.iValid && bus.oReady;
  assign outDone    = (stateReg == OUTPUT) && bus.iReady;
  assign bus.oReady = (stateReg == ACCUM);
  assign bus.oValid = (stateReg == OUTPUT);
  assign bus.oErr   = errReg;

  hog_bin_split #(
    .NBINS  (NBINS),
    .MAG_W  (MAG_W),
    .FRAC_W (FRAC_W),
    .BIN_W  (BIN_W)
  ) uSplit (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iEn    (accept),
    .iMag   (bus.iMag),
    .iAgl   (bus.iAgl),
    .oValid (p1Valid),
    .oErr   (p1Err),
    .oBin   (p1Bin),
    .oBin1  (p1Bin1),
    .oLo    (p1Lo),
    .oHi    (p1Hi)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stateReg <= ACCUM;
      cntReg   <= '0;
      errReg   <= 1'b0;
    end else begin
      if (p1Valid && p1Err) errReg <= 1'b1;
      case (stateReg)
        ACCUM: begin
          if (accept) begin
            if (cntReg == CNT_W'(CELL_PX - 1)) begin
              cntReg   <= '0;
              stateReg <= DRAIN;
            end else begin
              cntReg <= cntReg + 1'b1;
            end
          end
        end
        DRAIN:   stateReg <= OUTPUT;
        OUTPUT:  if (bus.iReady) stateReg <= ACCUM;
        default: stateReg <= ACCUM;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NBINS; gi++) begin : gBin
      logic [ACC_W-1:0] accReg;
      logic [ACC_W-1:0] accNext;
      logic [SUM_W-1:0] addVal;
      logic [SUM_W-1:0] sum;

      always_comb begin
        addVal = '0;
        if (p1Valid && (p1Bin == BIN_W'(gi)))  addVal = addVal + SUM_W'(p1Lo);
        if (p1Valid && (p1Bin1 == BIN_W'(gi))) addVal = addVal + SUM_W'(p1Hi);
        sum = SUM_W'(accReg) + addVal;
`ifdef HOG_HIST_ACC_SAT_EN
        // Adds are non-negative, so a clamped bin stays clamped until the clear.
        accNext = (sum > SUM_W'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : ACC_W'(sum);
`else
        accNext = ACC_W'(sum);
`endif
      end

      always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)      accReg <= '0;
        else if (outDone) accReg <= '0;
        else if (p1Valid) accReg <= accNext;
      end

      assign bus.oBins[gi*ACC_W +: ACC_W] = accReg;
    end
  endgenerate

endmodule
